// File: rtl/pipe_hazard_regs.sv
// pipe_hazard_regs: PC, IF/ID, ID/EX and EX/MEM control registers driven by the stall unit, with bubble counters
module pipe_hazard_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_IF,
  input  logic             en_IFID,
  input  logic             NOP_IFID,
  input  logic             NOP_IDEX,
  input  logic             pc_redirect,
  input  logic [31:0]      pc_target,
  input  logic [31:0]      inst_IF,
  input  logic             RegWrite_ID,
  input  logic             Branch_ID,
  input  logic             BranchN_ID,
  input  logic             Jump_ID,
  input  logic             MemRW_ID,
  input  logic [4:0]       Rd_addr_ID,
  output logic [31:0]      PC_out_IF,
  output logic [31:0]      PC_out_IFID,
  output logic [31:0]      inst_out_IFID,
  output logic             valid_IFID,
  output logic [31:0]      PC_out_IDEX,
  output logic             RegWrite_out_IDEX,
  output logic             Branch_out_IDEX,
  output logic             BranchN_out_IDEX,
  output logic             Jump_out_IDEX,
  output logic             MemRW_out_IDEX,
  output logic             valid_IDEX,
  output logic [4:0]       Rd_addr_out_IDEX,
  output logic             RegWrite_out_EXMem,
  output logic             Branch_out_EXMem,
  output logic             BranchN_out_EXMem,
  output logic             Jump_out_EXMem,
  output logic             valid_EXMem,
  output logic [4:0]       Rd_addr_out_EXMem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic live;
  assign live = !NOP_IDEX && valid_IFID;
  always_ff @(posedge clk or negedge rst)
    if (!rst) PC_out_IF <= RESET_PC;
    else PC_out_IF <= pc_redirect ? pc_target : en_IF ? PC_out_IF + 32'd4 : PC_out_IF;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      PC_out_IFID   <= '0;
      inst_out_IFID <= NOP_INST;
      valid_IFID    <= 1'b0;
    end else if (NOP_IFID) begin
      PC_out_IFID   <= PC_out_IF;
      inst_out_IFID <= NOP_INST;
      valid_IFID    <= 1'b0;
    end else if (en_IFID) begin
      PC_out_IFID   <= PC_out_IF;
      inst_out_IFID <= inst_IF;
      valid_IFID    <= 1'b1;
    end
  // a bubble in IF/ID carries no real instruction, so its decoded controls are discarded
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      PC_out_IDEX       <= '0;
      RegWrite_out_IDEX <= 1'b0;
      Branch_out_IDEX   <= 1'b0;
      BranchN_out_IDEX  <= 1'b0;
      Jump_out_IDEX     <= 1'b0;
      MemRW_out_IDEX    <= 1'b0;
      valid_IDEX        <= 1'b0;
      Rd_addr_out_IDEX  <= '0;
    end else begin
      PC_out_IDEX       <= PC_out_IFID;
      RegWrite_out_IDEX <= live && RegWrite_ID;
      Branch_out_IDEX   <= live && Branch_ID;
      BranchN_out_IDEX  <= live && BranchN_ID;
      Jump_out_IDEX     <= live && Jump_ID;
      MemRW_out_IDEX    <= live && MemRW_ID;
      valid_IDEX        <= live;
      Rd_addr_out_IDEX  <= NOP_IDEX ? 5'd0 : Rd_addr_ID;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWrite_out_EXMem <= 1'b0;
      Branch_out_EXMem   <= 1'b0;
      BranchN_out_EXMem  <= 1'b0;
      Jump_out_EXMem     <= 1'b0;
      valid_EXMem        <= 1'b0;
      Rd_addr_out_EXMem  <= '0;
    end else begin
      RegWrite_out_EXMem <= RegWrite_out_IDEX;
      Branch_out_EXMem   <= Branch_out_IDEX;
      BranchN_out_EXMem  <= BranchN_out_IDEX;
      Jump_out_EXMem     <= Jump_out_IDEX;
      valid_EXMem        <= valid_IDEX;
      Rd_addr_out_EXMem  <= Rd_addr_out_IDEX;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (NOP_IDEX && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (NOP_IFID && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule
